// File: rtl/fluxo_nivel_jogada_if.sv
// Signal bundle between the game control unit (master) and the per-level play engine (slave).
interface fluxo_nivel_jogada_if;
    logic       zeraN;
    logic       contaN;
    logic       zeraM;
    logic [3:0] botoes;
    logic       nivel_concluido;
    logic       nivelIgualUltimoNivel;
    logic       nivelMenorOuIgualUltimoNivel;
    logic       jogada_certa;
    logic       jogada_errada;
    logic [3:0] db_nivel;
    logic [3:0] db_jogada;
    logic [2:0] db_estado;

    modport master (
        output zeraN, contaN, zeraM, botoes,
        input  nivel_concluido, nivelIgualUltimoNivel, nivelMenorOuIgualUltimoNivel,
               jogada_certa, jogada_errada, db_nivel, db_jogada, db_estado
    );

    modport slave (
        input  zeraN, contaN, zeraM, botoes,
        output nivel_concluido, nivelIgualUltimoNivel, nivelMenorOuIgualUltimoNivel,
               jogada_certa, jogada_errada, db_nivel, db_jogada, db_estado
    );
endinterface

// File: rtl/fluxo_nivel_jogada.sv
// Per-level play engine: level counter N, move counter M and the move-judging FSM.
// Optional idle timeout per move is enabled by defining JOGADA_TIMEOUT_EN.
module fluxo_nivel_jogada #(
    parameter int          ULTIMO_NIVEL = 15,
    parameter logic [31:0] SEQ          = 32'hB4E1_72D8
`ifdef JOGADA_TIMEOUT_EN
    , parameter int        TIMEOUT_CICLOS = 5000
`endif
) (
    input logic               clock,
    input logic               reset,
    fluxo_nivel_jogada_if.slave bus
);

    typedef enum logic [2:0] {
        BLOQUEADO = 3'b000,
        ESPERA    = 3'b001,
        COMPARA   = 3'b010,
        ACERTO    = 3'b011,
        ERRO      = 3'b100,
        FIM_NIVEL = 3'b101
    } estado_t;

    localparam logic [3:0] ULTIMO = 4'(ULTIMO_NIVEL);

    estado_t    estado;
    logic [3:0] nivel;
    logic [3:0] jogada_m;
    logic [3:0] jogada;
    logic [3:0] botoes_ant;
    logic       certa;
    logic       errada;
    logic       concluido;
    logic       press;
    logic [1:0] botao_seq;
    logic [3:0] esperado;
    logic       correto;

    assign press     = (botoes_ant == 4'b0000) && (bus.botoes != 4'b0000);
    assign botao_seq = SEQ[{jogada_m, 1'b0} +: 2];
    assign esperado  = 4'b0001 << botao_seq;
    assign correto   = (jogada == esperado);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            nivel      <= 4'd0;
            botoes_ant <= 4'd0;
        end else begin
            botoes_ant <= bus.botoes;
            if (bus.zeraN)
                nivel <= 4'd0;
            else if (bus.contaN && (nivel != ULTIMO))
                nivel <= nivel + 4'd1;
        end
    end

`ifdef JOGADA_TIMEOUT_EN
    localparam logic [12:0] LIMITE = 13'(TIMEOUT_CICLOS - 1);
    logic [12:0] ocioso;
`endif

    // zeraM overrides every transition; pulse outputs are registered alongside the state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado    <= BLOQUEADO;
            jogada_m  <= 4'd0;
            jogada    <= 4'd0;
            certa     <= 1'b0;
            errada    <= 1'b0;
            concluido <= 1'b0;
`ifdef JOGADA_TIMEOUT_EN
            ocioso    <= 13'd0;
`endif
        end else begin
            certa     <= 1'b0;
            errada    <= 1'b0;
            concluido <= 1'b0;
            if (bus.zeraM) begin
                estado   <= ESPERA;
                jogada_m <= 4'd0;
                jogada   <= 4'd0;
`ifdef JOGADA_TIMEOUT_EN
                ocioso   <= 13'd0;
`endif
            end else begin
                case (estado)
                    BLOQUEADO: estado <= BLOQUEADO;
                    ESPERA: begin
                        if (press) begin
                            jogada <= bus.botoes;
                            estado <= COMPARA;
`ifdef JOGADA_TIMEOUT_EN
                            ocioso <= 13'd0;
                        end else if (ocioso == LIMITE) begin
                            errada <= 1'b1;
                            estado <= ERRO;
                        end else begin
                            ocioso <= ocioso + 13'd1;
`endif
                        end
                    end
                    COMPARA: begin
                        if (correto && (jogada_m == nivel)) begin
                            certa     <= 1'b1;
                            concluido <= 1'b1;
                            estado    <= FIM_NIVEL;
                        end else if (correto) begin
                            certa  <= 1'b1;
                            estado <= ACERTO;
                        end else begin
                            errada <= 1'b1;
                            estado <= ERRO;
                        end
                    end
                    ACERTO: begin
                        jogada_m <= jogada_m + 4'd1;
                        estado   <= ESPERA;
`ifdef JOGADA_TIMEOUT_EN
                        ocioso   <= 13'd0;
`endif
                    end
                    ERRO: begin
                        jogada_m <= 4'd0;
                        estado   <= ESPERA;
`ifdef JOGADA_TIMEOUT_EN
                        ocioso   <= 13'd0;
`endif
                    end
                    FIM_NIVEL: estado <= BLOQUEADO;
                    default:   estado <= BLOQUEADO;
                endcase
            end
        end
    end

    assign bus.nivel_concluido              = concluido;
    assign bus.jogada_certa                 = certa;
    assign bus.jogada_errada                = errada;
    assign bus.nivelIgualUltimoNivel        = (nivel == ULTIMO);
    assign bus.nivelMenorOuIgualUltimoNivel = (int'(nivel) <= ULTIMO_NIVEL);
    assign bus.db_nivel                     = nivel;
    assign bus.db_jogada                    = jogada_m;
    assign bus.db_estado                    = estado;

endmodule

// File: tb/tb_fluxo_nivel_jogada.sv
// Table-driven bench for fluxo_nivel_jogada with hand-written multi-cycle sequences.
// With JOGADA_TIMEOUT_EN defined the DUT runs with TIMEOUT_CICLOS=8 and the timeout is checked.
module tb_fluxo_nivel_jogada;

    typedef struct {
        logic       zn;
        logic       cn;
        logic       zm;
        logic [3:0] bot;
        logic       certa;
        logic       errada;
        logic       concl;
        logic [3:0] jog;
        logic [2:0] est;
        logic [3:0] niv;
    } vec_t;

`ifdef JOGADA_TIMEOUT_EN
    localparam int HOLD = 5;
`else
    localparam int HOLD = 10;
`endif

    logic clock;
    logic reset;
    int   n_checks;
    int   n_fail;
    vec_t tabela[$];

    fluxo_nivel_jogada_if bus();

`ifdef JOGADA_TIMEOUT_EN
    fluxo_nivel_jogada #(.TIMEOUT_CICLOS(8)) dut (.clock(clock), .reset(reset), .bus(bus));
`else
    fluxo_nivel_jogada dut (.clock(clock), .reset(reset), .bus(bus));
`endif

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic apply_stimulus(input logic zn, input logic cn, input logic zm, input logic [3:0] bot);
        bus.zeraN  = zn;
        bus.contaN = cn;
        bus.zeraM  = zm;
        bus.botoes = bot;
        @(posedge clock);
        #1;
    endtask

    task automatic check_output(input string nome, input int atual, input int esperado);
        n_checks++;
        if (atual != esperado) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", nome, atual, esperado);
        end
    endtask

    task automatic check_row(input string tag, input logic certa, input logic errada, input logic concl,
                             input logic [3:0] jog, input logic [2:0] est, input logic [3:0] niv);
        check_output({tag, " jogada_certa"}, bus.jogada_certa, certa);
        check_output({tag, " jogada_errada"}, bus.jogada_errada, errada);
        check_output({tag, " nivel_concluido"}, bus.nivel_concluido, concl);
        check_output({tag, " db_jogada"}, bus.db_jogada, jog);
        check_output({tag, " db_estado"}, bus.db_estado, est);
        check_output({tag, " db_nivel"}, bus.db_nivel, niv);
        check_output({tag, " igual_ultimo"}, bus.nivelIgualUltimoNivel, (niv == 4'd15));
        check_output({tag, " menor_ou_igual"}, bus.nivelMenorOuIgualUltimoNivel, 1);
    endtask

    function automatic vec_t mk(input logic zn, input logic cn, input logic zm, input logic [3:0] bot,
                                input logic certa, input logic errada, input logic concl,
                                input logic [3:0] jog, input logic [2:0] est, input logic [3:0] niv);
        vec_t v;
        v.zn = zn; v.cn = cn; v.zm = zm; v.bot = bot;
        v.certa = certa; v.errada = errada; v.concl = concl;
        v.jog = jog; v.est = est; v.niv = niv;
        return v;
    endfunction

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        bus.zeraN = 1'b0; bus.contaN = 1'b0; bus.zeraM = 1'b0; bus.botoes = 4'b0000;

        // SEQ = B4E1_72D8: moves 0,1,2 expect buttons 0,2,1 -> 0001, 0100, 0010
        // level 0: one correct move finishes it
        tabela.push_back(mk(1,0,1,4'b0000, 0,0,0, 0,3'd1,0));
        tabela.push_back(mk(0,0,0,4'b0001, 0,0,0, 0,3'd2,0));
        tabela.push_back(mk(0,0,0,4'b0001, 1,0,1, 0,3'd5,0));
        tabela.push_back(mk(0,0,0,4'b0000, 0,0,0, 0,3'd0,0));
        // level 2: three correct moves
        tabela.push_back(mk(0,1,0,4'b0000, 0,0,0, 0,3'd0,1));
        tabela.push_back(mk(0,1,0,4'b0000, 0,0,0, 0,3'd0,2));
        tabela.push_back(mk(0,0,1,4'b0000, 0,0,0, 0,3'd1,2));
        tabela.push_back(mk(0,0,0,4'b0001, 0,0,0, 0,3'd2,2));
        tabela.push_back(mk(0,0,0,4'b0000, 1,0,0, 0,3'd3,2));
        tabela.push_back(mk(0,0,0,4'b0000, 0,0,0, 1,3'd1,2));
        tabela.push_back(mk(0,0,0,4'b0100, 0,0,0, 1,3'd2,2));
        tabela.push_back(mk(0,0,0,4'b0000, 1,0,0, 1,3'd3,2));
        tabela.push_back(mk(0,0,0,4'b0000, 0,0,0, 2,3'd1,2));
        tabela.push_back(mk(0,0,0,4'b0010, 0,0,0, 2,3'd2,2));
        tabela.push_back(mk(0,0,0,4'b0000, 1,0,1, 2,3'd5,2));
        tabela.push_back(mk(0,0,0,4'b0000, 0,0,0, 2,3'd0,2));
        // level 2: correct, correct, wrong, then a full correct run
        tabela.push_back(mk(0,0,1,4'b0000, 0,0,0, 0,3'd1,2));
        tabela.push_back(mk(0,0,0,4'b0001, 0,0,0, 0,3'd2,2));
        tabela.push_back(mk(0,0,0,4'b0000, 1,0,0, 0,3'd3,2));
        tabela.push_back(mk(0,0,0,4'b0000, 0,0,0, 1,3'd1,2));
        tabela.push_back(mk(0,0,0,4'b0100, 0,0,0, 1,3'd2,2));
        tabela.push_back(mk(0,0,0,4'b0000, 1,0,0, 1,3'd3,2));
        tabela.push_back(mk(0,0,0,4'b0000, 0,0,0, 2,3'd1,2));
        tabela.push_back(mk(0,0,0,4'b0001, 0,0,0, 2,3'd2,2));
        tabela.push_back(mk(0,0,0,4'b0000, 0,1,0, 2,3'd4,2));
        tabela.push_back(mk(0,0,0,4'b0000, 0,0,0, 0,3'd1,2));
        tabela.push_back(mk(0,0,0,4'b0001, 0,0,0, 0,3'd2,2));
        tabela.push_back(mk(0,0,0,4'b0000, 1,0,0, 0,3'd3,2));
        tabela.push_back(mk(0,0,0,4'b0000, 0,0,0, 1,3'd1,2));
        tabela.push_back(mk(0,0,0,4'b0100, 0,0,0, 1,3'd2,2));
        tabela.push_back(mk(0,0,0,4'b0000, 1,0,0, 1,3'd3,2));
        tabela.push_back(mk(0,0,0,4'b0000, 0,0,0, 2,3'd1,2));
        tabela.push_back(mk(0,0,0,4'b0010, 0,0,0, 2,3'd2,2));
        tabela.push_back(mk(0,0,0,4'b0000, 1,0,1, 2,3'd5,2));
        tabela.push_back(mk(0,0,0,4'b0000, 0,0,0, 2,3'd0,2));
        // button rising while zeraM is high is not a press once zeraM drops
        tabela.push_back(mk(0,0,1,4'b0001, 0,0,0, 0,3'd1,2));
        tabela.push_back(mk(0,0,0,4'b0001, 0,0,0, 0,3'd1,2));
        tabela.push_back(mk(0,0,0,4'b0000, 0,0,0, 0,3'd1,2));
        // multi-bit press is wrong
        tabela.push_back(mk(0,0,0,4'b0011, 0,0,0, 0,3'd2,2));
        tabela.push_back(mk(0,0,0,4'b0011, 0,1,0, 0,3'd4,2));

        repeat (2) @(posedge clock);
        #1;
        check_row("reset_held", 0,0,0, 0,3'd0,0);
        reset = 1'b0;
        #1;
        check_row("reset_released", 0,0,0, 0,3'd0,0);

        for (int i = 0; i < tabela.size(); i++) begin
            apply_stimulus(tabela[i].zn, tabela[i].cn, tabela[i].zm, tabela[i].bot);
            check_row($sformatf("row%0d", i), tabela[i].certa, tabela[i].errada, tabela[i].concl,
                      tabela[i].jog, tabela[i].est, tabela[i].niv);
        end

        // holding the multi-bit button produces no further evaluation
        for (int i = 0; i < HOLD; i++) begin
            apply_stimulus(0, 0, 0, 4'b0011);
            check_row($sformatf("hold%0d", i), 0,0,0, 0,3'd1,2);
        end
        apply_stimulus(0, 0, 0, 4'b0000);
        check_row("hold_release", 0,0,0, 0,3'd1,2);

        // async reset, then presses in BLOQUEADO are ignored
        #2 reset = 1'b1;
        #1 check_row("reset_espera", 0,0,0, 0,3'd0,0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(0, 0, 0, (i == 0) ? 4'b0001 : 4'b0000);
            check_row($sformatf("bloq%0d", i), 0,0,0, 0,3'd0,0);
        end

        // N saturates at 15
        for (int i = 1; i <= 20; i++) begin
            apply_stimulus(0, 1, 0, 4'b0000);
            check_output($sformatf("conta%0d db_nivel", i), bus.db_nivel, (i > 15) ? 15 : i);
        end
        check_row("saturado", 0,0,0, 0,3'd0,15);
        apply_stimulus(1, 1, 0, 4'b0000);
        check_row("zeraN_prio", 0,0,0, 0,3'd0,0);

        // zeraM beats a pending FIM_NIVEL; contaN moves N at once
        apply_stimulus(0, 0, 1, 4'b0000);
        apply_stimulus(0, 0, 0, 4'b0001);
        check_row("fim_pend", 0,0,0, 0,3'd2,0);
        apply_stimulus(0, 1, 1, 4'b0000);
        check_row("zeraM_prio", 0,0,0, 0,3'd1,1);

        // contaN during play leaves M alone, then reset mid-COMPARA
        apply_stimulus(0, 0, 0, 4'b0001);
        apply_stimulus(0, 0, 0, 4'b0000);
        check_row("n1_acerto", 1,0,0, 0,3'd3,1);
        apply_stimulus(0, 0, 0, 4'b0000);
        apply_stimulus(0, 1, 0, 4'b0000);
        check_row("conta_play", 0,0,0, 1,3'd1,2);
        apply_stimulus(0, 0, 0, 4'b0100);
        check_row("mid_compara", 0,0,0, 1,3'd2,2);
        #2 reset = 1'b1;
        #1 check_row("reset_compara", 0,0,0, 0,3'd0,0);
        reset = 1'b0;
        apply_stimulus(0, 0, 0, 4'b0000);

`ifdef JOGADA_TIMEOUT_EN
        apply_stimulus(0, 0, 1, 4'b0000);
        for (int i = 1; i <= 8; i++) begin
            apply_stimulus(0, 0, 0, 4'b0000);
            check_output($sformatf("timeout%0d jogada_errada", i), bus.jogada_errada, (i == 8) ? 1 : 0);
            check_output($sformatf("timeout%0d db_estado", i), bus.db_estado, (i == 8) ? 4 : 1);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fluxo_nivel_jogada.md
Name: fluxo_nivel_jogada

Overview:
Per-level play engine that closes the loop with the game control unit.
- Consumes the control unit's zeraN, contaN and zeraM strobes.
- Holds the level counter N and the move counter M, and judges the player's button presses against a fixed move sequence.
- Returns nivel_concluido, nivelIgualUltimoNivel and nivelMenorOuIgualUltimoNivel.
- Level N (0-based) requires N+1 correct consecutive moves.

Parameters:
ULTIMO_NIVEL, 15, index of last level; N saturates here (must be ≤ 15)
SEQ, 32'hB4E1_72D8, move table; expected move for index M is SEQ[2M+1:2M] (button number 0..3)
TIMEOUT_CICLOS, 5000, idle cycles per move before a timeout error (used only with the optional feature)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
zeraN  in  1  clear level counter N
contaN  in  1  increment level counter N
zeraM  in  1  clear move counter M and rearm play FSM
botoes  in  4  player buttons, one bit per button, already debounced, active-high
nivel_concluido  out  1  one-cycle pulse: level N finished correctly
nivelIgualUltimoNivel  out  1  N == ULTIMO_NIVEL (combinational from N)
nivelMenorOuIgualUltimoNivel  out  1  N <= ULTIMO_NIVEL (combinational from N)
jogada_certa  out  1  one-cycle pulse per correct move
jogada_errada  out  1  one-cycle pulse per wrong move or timeout
db_nivel  out  4  N
db_jogada  out  4  M
db_estado  out  3  play FSM state code

Behaviour:
Reset:
- N=0, M=0, state BLOQUEADO, button history register=0.
- All pulse outputs 0; db_estado=3'b000.

Level counter N (4 bits):
- zeraN → 0.
- Otherwise contaN → N+1, saturating at ULTIMO_NIVEL.
- zeraN has priority over contaN in the same cycle.

Button edge detection:
- botoes_ant is registered every cycle.
- A press is botoes_ant==0 && botoes!=0 (one press per release).

FSM states and codes:
- BLOQUEADO 000: buttons ignored. Leaves only via zeraM.
- ESPERA 001: on a press, latch botoes into jogada → COMPARA.
- COMPARA 010: correct iff jogada is exactly one-hot and equals 1<<SEQ[2M+1:2M].
  - Correct and M==N → FIM_NIVEL.
  - Correct and M<N → ACERTO.
  - Wrong, including multi-bit or non-one-hot → ERRO.
- ACERTO 011: jogada_certa=1; M<=M+1 → ESPERA.
- ERRO 100: jogada_errada=1; M<=0 (level restarts) → ESPERA.
- FIM_NIVEL 101: jogada_certa=1 and nivel_concluido=1, both for exactly one cycle → BLOQUEADO.

Latency:
- Press edge at cycle t → COMPARA at t+1 → pulse outputs at t+2.
- Presses arriving while not in ESPERA are dropped.

zeraM:
- Synchronous, highest priority over every FSM transition: M<=0, state<=ESPERA, pending jogada discarded.
- Held high continuously: FSM stays in ESPERA, no press is accepted.
- An edge present in the same cycle zeraM deasserts is not accepted.

Simultaneous events:
- zeraM with FIM_NIVEL: zeraM wins, no nivel_concluido pulse.
- contaN during play: N changes immediately; M is unaffected.

Wrap-around:
- M never exceeds N because FIM_NIVEL catches M==N; M is 4 bits.
- With ULTIMO_NIVEL=15, M reaches 15 and the SEQ index is 0..15.

Reset mid-operation: immediate return to reset values, regardless of state.

Optional Feature:
Macro JOGADA_TIMEOUT_EN.
- Defined:
  - A 13-bit idle counter clears on entry to ESPERA and on any press; it counts each cycle spent in ESPERA.
  - Reaching TIMEOUT_CICLOS-1 → ERRO: jogada_errada pulse, M=0.
  - zeraM clears the counter.
- Not defined: no counter; ESPERA waits indefinitely.

Test Plan:
1. Reset, zeraN+zeraM one cycle, press the correct button for M=0 (N=0) → nivel_concluido and jogada_certa pulse 2 cycles after the edge; state BLOQUEADO; db_jogada=0.
2. contaN ×2 then zeraM, N=2: press moves SEQ[0],SEQ[1],SEQ[2] → jogada_certa ×3, db_jogada 0→1→2, one nivel_concluido on the third move.
3. N=2, correct, correct, wrong → jogada_errada pulse, db_jogada returns to 0, no nivel_concluido; a following correct sequence of 3 completes the level.
4. Press 4'b0011 in ESPERA → jogada_errada; button held high for 10 cycles → only one evaluation; press while BLOQUEADO → no pulse.
5. contaN ×20 → db_nivel=15, nivelIgualUltimoNivel=1, nivelMenorOuIgualUltimoNivel=1; zeraN with contaN same cycle → N=0.
6. JOGADA_TIMEOUT_EN with TIMEOUT_CICLOS=8: zeraM, no press → jogada_errada 8 cycles after entering ESPERA; assert reset mid-COMPARA → all outputs 0, state 000 immediately.
